// File: rtl/ddr_line_reader.sv
// Ping-pong line buffer between the DDR read arbiter and the display path.
// Fetches 256-bit line bursts and replays them as RGB565 pixels aligned to vs_in/de_in.
module ddr_line_reader #(
  parameter int         DQ_WIDTH   = 32,
  parameter int         COLUMN_NUM = 1280,
  parameter int         ROW_NUM    = 720,
  parameter logic [3:0] IMAGE_TAG  = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vs_in,
  input  logic                    de_in,
  output logic                    rd_req,
  output logic [3:0]              rd_req_id,
  output logic [9:0]              rd_req_row,
  input  logic                    rd_req_ack,
  input  logic [DQ_WIDTH*8-1:0]   ddr_data_in,
  input  logic                    ddr_data_valid,
  output logic [15:0]             rgb565_out,
  output logic                    de_out,
  output logic                    vs_out,
  output logic                    underflow_flag
);

  localparam int LINE_WORDS = COLUMN_NUM / 16;
  localparam int BW = $clog2(LINE_WORDS);
  localparam int AW = $clog2(2 * LINE_WORDS);
  localparam int PW = $clog2(COLUMN_NUM + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);
  localparam logic [9:0]    ROW_END   = 10'(ROW_NUM);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

  state_t          state_q, state_d;
  logic            vs_q, frame_act_q, frame_act_d;
  logic [9:0]      fetch_row_q, fetch_row_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [9:0]      disp_row_q, disp_row_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            line_ok_q, line_ok_d;
  logic            de_q;
  logic [15:0]     rgb_q, rgb_d;
  logic            underflow_q, underflow_d;
  logic [3:0]      id_q;

  logic [DQ_WIDTH*8-1:0] line_buf [2*LINE_WORDS];

  logic            frame_start, vs_rise, de_rise, de_fall;
  logic            fill_we, last_beat, pix_ok;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DQ_WIDTH*8-1:0] rd_word;
  logic [3:0]      lane;

  assign frame_start = vs_q & ~vs_in;
  assign vs_rise     = ~vs_q & vs_in;
  assign de_rise     = de_in & ~de_q;
  assign de_fall     = ~de_in & de_q;

  // A beat arriving in the same cycle as an abort is dropped.
  assign fill_we   = (state_q == S_FILL) && ddr_data_valid && !vs_rise;
  assign last_beat = fill_we && (beat_q == BEAT_LAST);

  assign wr_addr = (wr_bank_q ? AW'(LINE_WORDS) : '0) + AW'(beat_q);
  assign rd_addr = (rd_bank_q ? AW'(LINE_WORDS) : '0) + AW'(pix_q >> 4);
  assign rd_word = line_buf[rd_addr];
  assign lane    = pix_q[3:0];

  always_comb begin
    state_d     = state_q;
    frame_act_d = frame_act_q;
    fetch_row_d = fetch_row_q;
    beat_d      = beat_q;
    wr_bank_d   = wr_bank_q;
    if (frame_start) begin
      state_d     = S_REQ;
      frame_act_d = 1'b1;
      fetch_row_d = '0;
      beat_d      = '0;
      wr_bank_d   = 1'b0;
    end else if (vs_rise) begin
      state_d     = S_IDLE;
      frame_act_d = 1'b0;
      beat_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_act_q && (fetch_row_q < ROW_END) && !full_q[wr_bank_q])
            state_d = S_REQ;
        end
        S_REQ: begin
          if (rd_req_ack) state_d = S_FILL;
        end
        S_FILL: begin
          if (ddr_data_valid) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == BEAT_LAST) begin
              beat_d      = '0;
              wr_bank_d   = ~wr_bank_q;
              fetch_row_d = fetch_row_q + 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    full_d     = full_q;
    rd_bank_d  = rd_bank_q;
    disp_row_d = disp_row_q;
    if (last_beat) full_d[wr_bank_q] = 1'b1;
    // Same-bank set/clear only happens after an underflow; the clear wins.
    if (de_fall) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      disp_row_d        = disp_row_q + 1'b1;
    end
    if (frame_start) begin
      full_d     = '0;
      rd_bank_d  = 1'b0;
      disp_row_d = '0;
    end
  end

  always_comb begin
    pix_d       = de_in ? pix_q + 1'b1 : '0;
    line_ok_d   = de_rise ? full_q[rd_bank_q] : line_ok_q;
    pix_ok      = de_rise ? full_q[rd_bank_q] : line_ok_q;
    rgb_d       = (de_in && pix_ok) ? rd_word[{lane, 4'b0000} +: 16] : 16'h0000;
    underflow_d = de_rise & ~full_q[rd_bank_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      frame_act_q <= 1'b0;
      fetch_row_q <= '0;
      beat_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      disp_row_q  <= '0;
      pix_q       <= '0;
      line_ok_q   <= 1'b0;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_in;
      frame_act_q <= frame_act_d;
      fetch_row_q <= fetch_row_d;
      beat_q      <= beat_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      disp_row_q  <= disp_row_d;
      pix_q       <= pix_d;
      line_ok_q   <= line_ok_d;
      de_q        <= de_in;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
      id_q        <= IMAGE_TAG;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) line_buf[wr_addr] <= ddr_data_in;
  end

  assign rd_req         = (state_q == S_REQ);
  assign rd_req_row     = fetch_row_q;
  assign rd_req_id      = id_q;
  assign rgb565_out     = rgb_q;
  assign de_out         = de_q;
  assign vs_out         = vs_q;
  assign underflow_flag = underflow_q;

endmodule

// File: tb/tb_ddr_line_reader.sv
// Directed bench for ddr_line_reader: fetch handshake, pixel order, underflow,
// gappy DDR data, spurious valids and mid-fetch abort.
module tb_ddr_line_reader;

  logic         clk = 1'b0;
  logic         rst, vs_in, de_in, rd_req_ack, ddr_data_valid;
  logic [255:0] ddr_data_in;
  logic         rd_req, de_out, vs_out, underflow_flag;
  logic [3:0]   rd_req_id;
  logic [9:0]   rd_req_row;
  logic [15:0]  rgb565_out;

  int n_chk  = 0;
  int n_pass = 0;

  ddr_line_reader dut (
    .clk            (clk),
    .rst            (rst),
    .vs_in          (vs_in),
    .de_in          (de_in),
    .rd_req         (rd_req),
    .rd_req_id      (rd_req_id),
    .rd_req_row     (rd_req_row),
    .rd_req_ack     (rd_req_ack),
    .ddr_data_in    (ddr_data_in),
    .ddr_data_valid (ddr_data_valid),
    .rgb565_out     (rgb565_out),
    .de_out         (de_out),
    .vs_out         (vs_out),
    .underflow_flag (underflow_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // mode 0: word0 lanes 0..15, word k = {16{k}}; mode m>0: {16{m*256+k}}
  function automatic logic [255:0] beat_word(input int mode, input int k);
    logic [255:0] w;
    logic [15:0]  v;
    if (mode == 0 && k == 0) begin
      for (int l = 0; l < 16; l++) w[16*l +: 16] = 16'(l);
    end else begin
      v = 16'(mode * 256 + k);
      w = {16{v}};
    end
    return w;
  endfunction

  // mode 3 = black line (underflow)
  function automatic logic [15:0] exp_pix(input int mode, input int p);
    if (mode == 3) return 16'h0000;
    if (mode == 0 && (p >> 4) == 0) return 16'(p % 16);
    return 16'(mode * 256 + (p >> 4));
  endfunction

  task automatic feed(input int mode, input int nbeats, input int gap);
    for (int k = 0; k < nbeats; k++) begin
      ddr_data_valid = 1'b1;
      ddr_data_in    = beat_word(mode, k);
      @(negedge clk);
      for (int g = 0; g < gap; g++) begin
        ddr_data_valid = 1'b0;
        ddr_data_in    = '1;
        @(negedge clk);
      end
    end
    ddr_data_valid = 1'b0;
  endtask

  task automatic spurious(input int n);
    for (int i = 0; i < n; i++) begin
      ddr_data_valid = 1'b1;
      ddr_data_in    = {16{16'hdead}};
      @(negedge clk);
    end
    ddr_data_valid = 1'b0;
  endtask

  task automatic wait_req(input int row, input string tag);
    int t = 0;
    while (!rd_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_req"}, rd_req, 1);
    chk({tag, "_row"}, rd_req_row, row);
    chk({tag, "_id"}, rd_req_id, 1);
  endtask

  task automatic do_ack(input string tag);
    rd_req_ack = 1'b1;
    @(negedge clk);
    rd_req_ack = 1'b0;
    chk({tag, "_req_drop"}, rd_req, 0);
  endtask

  task automatic show_line(input int mode, input string tag, input int exp_uf);
    int hi = 0;
    int uf = 0;
    de_in = 1'b1;
    for (int p = 0; p < 1280; p++) begin
      @(negedge clk);
      if (de_out) hi++;
      if (underflow_flag) uf++;
      if (p == 0) chk({tag, "_uf_first"}, underflow_flag, exp_uf);
      chk({tag, "_pix"}, rgb565_out, exp_pix(mode, p));
    end
    de_in = 1'b0;
    @(negedge clk);
    if (underflow_flag) uf++;
    chk({tag, "_de_hi"}, hi, 1280);
    chk({tag, "_uf_cnt"}, uf, exp_uf);
    chk({tag, "_de_low"}, de_out, 0);
    chk({tag, "_rgb_low"}, rgb565_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    rd_req_ack = 1'b0; ddr_data_valid = 1'b0; ddr_data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", rd_req, 0);
    chk("rst_id", rd_req_id, 0);
    chk("rst_row", rd_req_row, 0);
    chk("rst_rgb", rgb565_out, 0);
    chk("rst_de", de_out, 0);
    chk("rst_vs", vs_out, 0);
    chk("rst_uf", underflow_flag, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_req", rd_req, 0);
    chk("idle_id", rd_req_id, 1);
    chk("idle_vs", vs_out, 1);

    vs_in = 1'b0;
    wait_req(0, "frame_start");
    spurious(3);
    chk("hold_req", rd_req, 1);
    do_ack("row0");
    feed(0, 80, 0);
    wait_req(1, "row1");
    spurious(2);
    do_ack("row1");
    feed(1, 80, 2);
    spurious(10);
    repeat (5) @(negedge clk);
    chk("both_full_no_req", rd_req, 0);

    show_line(0, "row0", 0);
    wait_req(2, "row2");
    show_line(1, "row1", 0);
    show_line(3, "underflow", 1);

    do_ack("row2");
    feed(2, 40, 0);
    vs_in = 1'b1;
    @(negedge clk);
    spurious(5);
    repeat (3) @(negedge clk);
    chk("abort_idle", rd_req, 0);
    vs_in = 1'b0;
    wait_req(0, "refetch");
    do_ack("refetch");
    feed(2, 80, 0);
    wait_req(1, "refetch_row1");
    show_line(2, "row0_new", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
